// File: rtl/ctrl_pkg.sv
// Shared types and defaults for the ctrl_seq control sequencer: opcode and
// state encodings, decoded op classes and the per-state control bundle.
package ctrl_pkg;

    localparam int IW_DEF     = 9;
    localparam int OPW_DEF    = 3;
    localparam int RAW_DEF    = 3;
    localparam int JPW_DEF    = 3;
    localparam int MEM_TO_DEF = 15;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_ADDI  = 3'b001,
        OP_XOR   = 3'b010,
        OP_LOAD  = 3'b011,
        OP_STORE = 3'b100,
        OP_JUMP  = 3'b101,
        OP_SUB   = 3'b110,
        OP_SHIFT = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_JUMP,
        CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic wen_r;
        logic wen_d;
        logic ldr;
        logic str;
        logic jump_en;
        logic illegal;
    } ctl_t;

    function automatic op_class_t classify(input op_t op);
        unique case (op)
            OP_AND, OP_XOR, OP_SUB: return CLS_ALU;
            OP_ADDI, OP_SHIFT:      return CLS_IMM;
            OP_LOAD:                return CLS_LOAD;
            OP_STORE:               return CLS_STORE;
            OP_JUMP:                return CLS_JUMP;
            default:                return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of the instruction register: field extracts, op class,
// immediate-path Rb forcing and the state-qualified control bundle.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int IW  = IW_DEF,
    parameter int OPW = OPW_DEF,
    parameter int RAW = RAW_DEF,
    parameter int JPW = JPW_DEF
) (
    input  logic [IW-1:0]  ir,
    input  state_t         state,
    output logic [OPW-1:0] aluop,
    output logic [JPW-1:0] jptr,
    output logic [RAW-1:0] ra,
    output logic [RAW-1:0] rb,
    output logic [RAW-1:0] wd,
    output op_class_t      op_class,
    output ctl_t           ctl
);

    logic [OPW-1:0] op_hi;
    logic           rb_force;

    assign aluop = ir[IW-1 -: OPW];
    assign jptr  = ir[JPW-1:0];
    assign ra    = ir[IW-OPW-1 -: RAW];
    assign wd    = ra;

    // Opcodes only live in the low three bits; any upper opcode bit set is undefined.
    assign op_hi    = aluop >> 3;
    assign op_class = (op_hi != '0) ? CLS_ILLEGAL : classify(op_t'(aluop[2:0]));

    assign rb_force = (op_class == CLS_IMM) || (op_class == CLS_LOAD) || (op_class == CLS_STORE);
    assign rb       = rb_force ? '0 : ir[IW-OPW-RAW-1 -: RAW];

    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch behind.
        ctl = '0;
        unique case (state)
            ST_EXEC: begin
                unique case (op_class)
                    CLS_ALU, CLS_IMM: ctl.wen_r   = 1'b1;
                    CLS_JUMP:         ctl.jump_en = 1'b1;
                    CLS_LOAD:         ctl.ldr     = 1'b1;
                    CLS_STORE: begin
                        ctl.str   = 1'b1;
                        ctl.wen_d = 1'b1;
                    end
                    default:          ctl.illegal = 1'b1;
                endcase
            end
            ST_MEM: begin
                if (op_class == CLS_LOAD) begin
                    ctl.ldr = 1'b1;
                end else begin
                    ctl.str   = 1'b1;
                    ctl.wen_d = 1'b1;
                end
            end
            ST_WB: begin
                ctl.ldr   = 1'b1;
                ctl.wen_r = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle IDLE/EXEC/MEM/WB control sequencer with memory stall and
// illegal-opcode detection. Define CTRL_MEM_TIMEOUT_EN to add the MEM_TO memory timeout.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int IW     = IW_DEF,
    parameter int OPW    = OPW_DEF,
    parameter int RAW    = RAW_DEF,
    parameter int JPW    = JPW_DEF,
    parameter int MEM_TO = MEM_TO_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [IW-1:0]  mach_code,
    input  logic           mem_ready,
    output logic [OPW-1:0] Aluop,
    output logic [JPW-1:0] Jptr,
    output logic [RAW-1:0] Ra,
    output logic [RAW-1:0] Rb,
    output logic [RAW-1:0] Wd,
    output logic           WenR,
    output logic           WenD,
    output logic           Ldr,
    output logic           Str,
    output logic           jump_en,
    output logic           pc_en,
    output logic           illegal,
    output logic           mem_err
);

    state_t        state;
    logic [IW-1:0] ir;
    op_class_t     op_class;
    ctl_t          ctl;
    logic          is_mem_op;
    logic          mem_timeout;

    if (MEM_TO < 1) begin : g_mem_to_check
        $error("ctrl_seq: MEM_TO must be at least 1");
    end

    ctrl_decode #(
        .IW (IW),
        .OPW(OPW),
        .RAW(RAW),
        .JPW(JPW)
    ) u_decode (
        .ir      (ir),
        .state   (state),
        .aluop   (Aluop),
        .jptr    (Jptr),
        .ra      (Ra),
        .rb      (Rb),
        .wd      (Wd),
        .op_class(op_class),
        .ctl     (ctl)
    );

    assign is_mem_op   = (op_class == CLS_LOAD) || (op_class == CLS_STORE);
    assign instr_ready = (state == ST_IDLE);
    assign WenR        = ctl.wen_r;
    assign WenD        = ctl.wen_d;
    assign Ldr         = ctl.ldr;
    assign Str         = ctl.str;
    assign jump_en     = ctl.jump_en;
    assign illegal     = ctl.illegal;

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TO + 1);

    logic [CNT_W-1:0] mem_cnt;

    // Cleared during EXEC so the first MEM cycle reads 0; exit happens before it can wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cnt <= '0;
        end else if (state == ST_EXEC) begin
            mem_cnt <= '0;
        end else if (state == ST_MEM) begin
            mem_cnt <= mem_cnt + 1'b1;
        end
    end

    assign mem_timeout = (state == ST_MEM) && (mem_cnt == CNT_W'(MEM_TO - 1));
`else
    assign mem_timeout = 1'b0;
`endif

    always_comb begin
        pc_en   = 1'b0;
        mem_err = 1'b0;
        unique case (state)
            ST_EXEC: pc_en = !is_mem_op;
            ST_MEM: begin
                if (mem_ready) begin
                    pc_en = (op_class == CLS_STORE);
                end else if (mem_timeout) begin
                    pc_en   = 1'b1;
                    mem_err = 1'b1;
                end
            end
            ST_WB:   pc_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            // NOTE: IR is a single control register, so it is reset to make Aluop/Ra/Rb/Wd read 0.
            ir    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            unique case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        ir    <= mach_code;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: state <= is_mem_op ? ST_MEM : ST_IDLE;
                ST_MEM: begin
                    if (mem_ready) begin
                        state <= (op_class == CLS_LOAD) ? ST_WB : ST_IDLE;
                    end else if (mem_timeout) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
